// File: rtl/aes_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_stream_loader
// Brief    : Byte-stream command front end that loads keys and plaintext
//            blocks into the AES core and supervises its handshakes.
// Revision : 1.0
// ============================================================================

module aes_stream_loader #(
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [255:0] key_in,
    output logic [1:0]   keylen,
    output logic         init,
    output logic [127:0] init_plain,
    output logic         next,
    input  logic         key_ready,
    input  logic         cipher_ready,
    input  logic         error,
    output logic         key_loaded,
    output logic         busy,
    output logic         frame_err,
    output logic         timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_tmo_last   = CW'(TIMEOUT - 1);
    localparam logic [7:0]    c_cmd_key    = 8'h4B;
    localparam logic [7:0]    c_cmd_plain  = 8'h50;
    localparam logic [4:0]    c_plain_last = 5'd15;

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_KLEN  = 3'd1,
        S_KEY   = 3'd2,
        S_KWAIT = 3'd3,
        S_PLAIN = 3'd4,
        S_PWAIT = 3'd5
    } state_t;

    state_t          r_state;
    logic [4:0]      r_byte_cnt;
    logic [4:0]      r_key_last;
    logic [CW-1:0]   r_tmo_cnt;
    logic            r_armed;

    logic            w_xfer;
    logic            w_tmo;
    logic [7:0]      w_shift;
    logic [255:0]    w_key_mask;
    logic [255:0]    w_key_byte;
    logic [127:0]    w_plain_mask;
    logic [127:0]    w_plain_byte;

    assign s_ready = (r_state == S_CMD) || (r_state == S_KLEN) ||
                     (r_state == S_KEY) || (r_state == S_PLAIN);
    assign busy    = (r_state != S_CMD);
    assign w_xfer  = s_valid && s_ready;
    assign w_tmo   = (r_tmo_cnt == c_tmo_last);

    // Byte k lands MSB-first, so it is shifted down by 8k from the top lane.
    assign w_shift      = {r_byte_cnt, 3'b000};
    assign w_key_mask   = {8'hFF, 248'b0} >> w_shift;
    assign w_key_byte   = {s_data, 248'b0} >> w_shift;
    assign w_plain_mask = {8'hFF, 120'b0} >> w_shift;
    assign w_plain_byte = {s_data, 120'b0} >> w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_CMD;
            r_byte_cnt  <= 5'd0;
            r_key_last  <= 5'd0;
            r_tmo_cnt   <= '0;
            r_armed     <= 1'b0;
            key_in      <= 256'd0;
            keylen      <= 2'd0;
            init_plain  <= 128'd0;
            init        <= 1'b0;
            next        <= 1'b0;
            key_loaded  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            init        <= 1'b0;
            next        <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;

            case (r_state)
                S_CMD: begin
                    if (w_xfer) begin
                        if (s_data == c_cmd_key) begin
                            key_loaded <= 1'b0;
                            r_state    <= S_KLEN;
                        end else if ((s_data == c_cmd_plain) && key_loaded) begin
                            r_byte_cnt <= 5'd0;
                            r_state    <= S_PLAIN;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                S_KLEN: begin
                    if (w_xfer) begin
                        if (s_data[1:0] == 2'b11) begin
                            frame_err <= 1'b1;
                            r_state   <= S_CMD;
                        end else begin
                            keylen     <= s_data[1:0];
                            key_in     <= 256'd0;
                            r_byte_cnt <= 5'd0;
                            case (s_data[1:0])
                                2'b00:   r_key_last <= 5'd15;
                                2'b01:   r_key_last <= 5'd23;
                                default: r_key_last <= 5'd31;
                            endcase
                            r_state    <= S_KEY;
                        end
                    end
                end

                S_KEY: begin
                    if (w_xfer) begin
                        key_in     <= (key_in & ~w_key_mask) | w_key_byte;
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                        if (r_byte_cnt == r_key_last) begin
                            init      <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_armed   <= 1'b0;
                            r_state   <= S_KWAIT;
                        end
                    end
                end

                // Priority: core error, then completion, then timeout.
                S_KWAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (error) begin
                        frame_err <= 1'b1;
                        r_state   <= S_CMD;
                    end else if (r_armed && key_ready) begin
                        key_loaded <= 1'b1;
                        r_state    <= S_CMD;
                    end else if (w_tmo) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_CMD;
                    end else if (!key_ready) begin
                        r_armed <= 1'b1;
                    end
                end

                S_PLAIN: begin
                    if (w_xfer) begin
                        init_plain <= (init_plain & ~w_plain_mask) | w_plain_byte;
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                        if (r_byte_cnt == c_plain_last) begin
                            next      <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_armed   <= 1'b0;
                            r_state   <= S_PWAIT;
                        end
                    end
                end

                S_PWAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (r_armed && cipher_ready) begin
                        r_state <= S_CMD;
                    end else if (w_tmo) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_CMD;
                    end else if (!cipher_ready) begin
                        r_armed <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_CMD;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stream_loader
// Brief    : Directed self-checking bench for aes_stream_loader.
// Revision : 1.0
// ============================================================================

module tb_aes_stream_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic [255:0] key_in;
    logic [1:0]   keylen;
    logic         init;
    logic [127:0] init_plain;
    logic         next;
    logic         key_ready;
    logic         cipher_ready;
    logic         error;
    logic         key_loaded;
    logic         busy;
    logic         frame_err;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_stream_loader #(.TIMEOUT(1023)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .key_in       (key_in),
        .keylen       (keylen),
        .init         (init),
        .init_plain   (init_plain),
        .next         (next),
        .key_ready    (key_ready),
        .cipher_ready (cipher_ready),
        .error        (error),
        .key_loaded   (key_loaded),
        .busy         (busy),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents one byte for exactly one clock edge; callers only send while s_ready is high.
    task automatic send_byte(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] key128;
        logic [127:0] pt128;
        logic [255:0] exp256;
        logic [255:0] exp192;
        int           n;
        int           pulses;
        int           bad_ready;

        key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt128  = 128'h3243f6a8885a308d313198a2e0370734;

        rst_n        = 1'b0;
        s_data       = 8'h00;
        s_valid      = 1'b0;
        key_ready    = 1'b0;
        cipher_ready = 1'b0;
        error        = 1'b0;
        repeat (3) @(negedge clk);

        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_key_in", key_in, 256'd0);
        chkw("rst_keylen", {254'd0, keylen}, 256'd0);
        chkw("rst_init_plain", {128'd0, init_plain}, 256'd0);
        chk1("rst_init", init, 1'b0);
        chk1("rst_next", next, 1'b0);
        chk1("rst_key_loaded", key_loaded, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain command with no key loaded, then an unknown command
        send_byte(8'h50);
        @(negedge clk);
        chk1("nokey_frame_err", frame_err, 1'b1);
        chk1("nokey_stay_cmd", busy, 1'b0);
        send_byte(8'h11);
        @(negedge clk);
        chk1("badcmd_frame_err", frame_err, 1'b1);
        @(negedge clk);
        chk1("badcmd_pulse_end", frame_err, 1'b0);

        // 128-bit key, key_ready rises 12 cycles after init
        send_byte(8'h4B);
        send_byte(8'h00);
        for (int i = 0; i < 16; i++) send_byte(key128[127-8*i -: 8]);
        @(negedge clk);
        chk1("k128_init", init, 1'b1);
        chk1("k128_wait_busy", busy, 1'b1);
        pulses    = 1;
        bad_ready = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (init) pulses++;
            if (s_ready) bad_ready++;
            if (i == 12) key_ready = 1'b1;
        end
        @(negedge clk);
        chki("k128_init_pulses", pulses, 1);
        chki("k128_ready_in_wait", bad_ready, 0);
        chk1("k128_key_loaded", key_loaded, 1'b1);
        chk1("k128_s_ready_after", s_ready, 1'b1);
        chkw("k128_key_in", key_in, {key128, 128'd0});
        chkw("k128_keylen", {254'd0, keylen}, 256'd0);
        key_ready = 1'b0;

        // Plain block, cipher_ready rises after 6 cycles
        send_byte(8'h50);
        for (int i = 0; i < 16; i++) send_byte(pt128[127-8*i -: 8]);
        @(negedge clk);
        chk1("pt_next", next, 1'b1);
        chk1("pt_s_ready_wait", s_ready, 1'b0);
        pulses    = 1;
        bad_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (next) pulses++;
            if (s_ready) bad_ready++;
            if (i == 6) cipher_ready = 1'b1;
        end
        @(negedge clk);
        chki("pt_next_pulses", pulses, 1);
        chki("pt_ready_in_wait", bad_ready, 0);
        chk1("pt_s_ready_after", s_ready, 1'b1);
        chkw("pt_init_plain", {128'd0, init_plain}, {128'd0, pt128});
        cipher_ready = 1'b0;

        // Invalid keylen
        send_byte(8'h4B);
        send_byte(8'h03);
        @(negedge clk);
        chk1("klen3_frame_err", frame_err, 1'b1);
        chk1("klen3_cmd", busy, 1'b0);
        chk1("klen3_no_init", init, 1'b0);
        chk1("klen3_key_cleared", key_loaded, 1'b0);

        // 256-bit key with upper keylen bits set; key_ready never rises
        exp256 = '0;
        for (int i = 0; i < 32; i++) exp256[255-8*i -: 8] = 8'(i);
        send_byte(8'h4B);
        send_byte(8'hFE);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        @(negedge clk);
        chk1("k256_init", init, 1'b1);
        chk1("k256_s_ready_wait", s_ready, 1'b0);
        n = 0;
        while (n < 2000 && !timeout_err) begin
            @(negedge clk);
            n++;
        end
        chki("k256_timeout_cycles", n, 1023);
        chk1("k256_key_loaded", key_loaded, 1'b0);
        chk1("k256_s_ready_after", s_ready, 1'b1);
        chkw("k256_keylen", {254'd0, keylen}, 256'd2);
        chkw("k256_key_in", key_in, exp256);
        @(negedge clk);
        chk1("k256_timeout_pulse_end", timeout_err, 1'b0);

        // Reset in the middle of a 192-bit key frame
        send_byte(8'h4B);
        send_byte(8'h01);
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chkw("midrst_key_in", key_in, 256'd0);
        chkw("midrst_keylen", {254'd0, keylen}, 256'd0);
        chkw("midrst_init_plain", {128'd0, init_plain}, 256'd0);
        chk1("midrst_s_ready", s_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_key_loaded", key_loaded, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 192-bit key after the reset
        exp192 = '0;
        for (int i = 0; i < 24; i++) exp192[255-8*i -: 8] = 8'hA0 + 8'(i);
        send_byte(8'h4B);
        send_byte(8'h01);
        for (int i = 0; i < 24; i++) send_byte(8'hA0 + 8'(i));
        @(negedge clk);
        chk1("k192_init", init, 1'b1);
        repeat (3) @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        chk1("k192_key_loaded", key_loaded, 1'b1);
        chkw("k192_keylen", {254'd0, keylen}, 256'd1);
        chkw("k192_key_in", key_in, exp192);
        key_ready = 1'b0;

        // Core error during key expansion
        send_byte(8'h4B);
        send_byte(8'h00);
        for (int i = 0; i < 16; i++) send_byte(8'h5A);
        @(negedge clk);
        error = 1'b1;
        @(negedge clk);
        chk1("kerr_frame_err", frame_err, 1'b1);
        chk1("kerr_key_loaded", key_loaded, 1'b0);
        chk1("kerr_s_ready", s_ready, 1'b1);
        error = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_stream_loader.md
# aes_stream_loader

Byte-stream front end for the AES core: accepts framed commands over a valid/ready byte interface, assembles key and plaintext blocks, and drives the core's `init`/`key_in`/`keylen` and `next`/`init_plain` inputs. It waits for `key_ready`/`cipher_ready` with a timeout and holds the byte stream off while the core is busy. It sits between the UART receive path and the AES core.

## Interface

- `TIMEOUT`, default 1023: maximum cycles to wait for a core handshake before flagging a timeout; counter width is `$clog2(TIMEOUT+1)`.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_data` in 8: incoming byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `key_in` out 256: assembled key, MSB-first.
- `keylen` out 2: 0 = 128-bit, 1 = 192-bit, 2 = 256-bit.
- `init` out 1: one-cycle key-expansion start pulse.
- `init_plain` out 128: assembled plaintext block, MSB-first.
- `next` out 1: one-cycle encryption start pulse.
- `key_ready` in 1: core key expansion complete (level).
- `cipher_ready` in 1: core cipher output valid (level).
- `error` in 1: core key error (level).
- `key_loaded` out 1: a key has been expanded successfully since the last reset or key frame.
- `busy` out 1: high in every state other than CMD.
- `frame_err` out 1: one-cycle pulse for a bad command, a bad keylen, or a core `error`.
- `timeout_err` out 1: one-cycle pulse when a handshake wait expires.

## Operation

- A transfer is a byte accepted when `s_valid && s_ready`.
- Frames:
  - 0x4B (key frame): a keylen byte, then N key bytes, where N = 16/24/32 for keylen[1:0] = 0/1/2.
  - 0x50 (plain frame): 16 plaintext bytes.
- States: CMD, KLEN, KEY, KWAIT, PLAIN, PWAIT.
- CMD:
  - 0x4B goes to KLEN and clears `key_loaded`.
  - 0x50 with `key_loaded`=1 goes to PLAIN.
  - 0x50 with `key_loaded`=0, or any other byte: pulse `frame_err`, stay in CMD.
- KLEN:
  - Low 2 bits of the byte = 3: pulse `frame_err`, return to CMD.
  - Otherwise latch `keylen`, clear `key_in` to 0 and the byte counter to 0, go to KEY.
  - Bits [7:2] of the keylen byte are ignored.
- KEY:
  - Byte k (0-based) is written to `key_in[255-8k -: 8]`; bytes not written stay 0.
  - Accepting byte N-1 goes to KWAIT.
- KWAIT:
  - Pulse `init` on the first cycle.
  - Wait until `key_ready` has been seen 0 and then 1 (two-phase; arming happens on the 0).
  - On completion, set `key_loaded`=1 and go to CMD.
  - `error`=1 at any cycle in KWAIT: pulse `frame_err`, leave `key_loaded`=0, go to CMD.
- PLAIN: byte k goes to `init_plain[127-8k -: 8]`. Accepting byte 15 goes to PWAIT.
- PWAIT:
  - Pulse `next` on the first cycle.
  - Wait until `cipher_ready` has been seen 0 and then 1, then go to CMD.
- Timeout:
  - The counter is cleared on entry to KWAIT or PWAIT and increments every cycle while in either state.
  - Reaching `TIMEOUT` without completion: pulse `timeout_err`, go to CMD. A KWAIT timeout leaves `key_loaded`=0.
- `key_in`, `keylen` and `init_plain` change only on accepted bytes in KLEN, KEY or PLAIN. They are therefore stable throughout KWAIT and PWAIT.
- `s_ready` = 1 in CMD, KLEN, KEY and PLAIN; 0 in KWAIT and PWAIT.

## Timing

- Reset values:
  - Registers: state = CMD; `key_in`=0, `keylen`=0, `init_plain`=0.
  - Pulses: `init`=0, `next`=0, `frame_err`=0, `timeout_err`=0.
  - `key_loaded`=0; `s_ready`=1; `busy`=0.
- Reset mid-frame or mid-wait aborts at once to CMD. Partially assembled data is discarded (registers return to 0).
- All outputs are registered except `s_ready` and `busy`, which decode the current state.
- Latency from the last byte accepted in cycle t:
  - State becomes KWAIT/PWAIT at t+1.
  - `init`/`next` is high during cycle t+1 only.
- Completion:
  - If the 0→1 qualification completes in cycle c, the state is CMD and `s_ready`=1 at c+1.
  - If completion and timeout land in the same cycle, completion wins.
  - If `error` and completion land in the same cycle, `error` wins.
- Back-to-back frames are allowed: a command byte can be accepted in the first CMD cycle.
- Input throughput: one byte per cycle in the receiving states.

## Test plan

- Reset, then the 128-bit key frame 4B 00 2B7E1516 28AED2A6 ABF71588 09CF4F3C, core model raising `key_ready` 12 cycles after `init`:
  - `key_in[255:128]` = 2b7e1516…4f3c and `key_in[127:0]` = 0.
  - `init` is a single pulse and `key_loaded` = 1.
  - `s_ready`=0 for the whole wait.
- Then plain frame 50 3243F6A8 885A308D 313198A2 E0370734:
  - `init_plain` = 3243f6a8…0734.
  - A single `next` pulse, exit on `cipher_ready`, and `s_ready` back to 1.
- Frame 50 sent before any key → `frame_err` pulse and state stays CMD. Byte 0x11 → `frame_err` pulse.
- Frame 4B 03 → `frame_err`, return to CMD, no `init`.
- 256-bit key frame with `key_ready` held low, `TIMEOUT`=1023 → `timeout_err` exactly 1023 cycles after entering KWAIT, and `key_loaded`=0.
- `rst_n` asserted after 10 of 24 bytes of a 192-bit key → outputs at reset values. A subsequent full frame loads correctly.
